// File: rtl/game_pkg.sv
// Shared game definitions: top-level game state encodings, scroll step size
// and the scroll scheduler FSM state type.
package game_pkg;

  typedef enum logic [2:0] {
    GS_WAIT        = 3'd0,
    GS_INFORMATION = 3'd1,
    GS_GAME        = 3'd2,
    GS_WIN         = 3'd3,
    GS_LOSE        = 3'd4
  } game_state_e;

  localparam int MAX_STEP = 32;
  localparam int BUMP_W   = 10;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_RUN  = 2'd1,
    SCH_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/bump_fifo.sv
// Small synchronous FIFO buffering bump amounts; flush empties it in one cycle.
module bump_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scroll_scheduler.sv
// Meters buffered jump bumps out as per-tick scroll steps, keeps the score
// and flags the win.
module scroll_scheduler
  import game_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] WIN_SCORE  = 16'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  state,
  input  logic        hold,
  input  logic        bump_valid,
  input  logic [9:0]  bump_amt,
  output logic        bump_ready,
  output logic [5:0]  step,
  output logic        step_valid,
  output logic [15:0] score,
  output logic        win,
  output logic        busy,
  output logic        dropped
);

  localparam logic [9:0] STEP_ACC = 10'(MAX_STEP);
  localparam logic [5:0] STEP_OUT = 6'(MAX_STEP);

  sched_state_e fsm_q;
  sched_state_e fsm_d;
  logic [9:0]   acc;
  logic [9:0]   head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         in_game;
  logic         flush;
  logic         run;
  logic         push;
  logic         pop;
  logic         tick_fire;
  logic         full_step;

  assign in_game   = (state == GS_GAME);
  assign flush     = !in_game || (fsm_q == SCH_IDLE);
  assign run       = in_game && (fsm_q == SCH_RUN);
  assign push      = run && bump_valid && bump_ready && (bump_amt != '0);
  assign pop       = run && (acc == '0) && !fifo_empty;
  assign tick_fire = run && tick && !win;
  assign full_step = hold || (acc >= STEP_ACC);
  assign busy      = (acc != '0) || !fifo_empty;

  bump_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUMP_W)
  ) u_bump_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bump_amt),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_q <= SCH_IDLE;
    else      fsm_q <= fsm_d;
  end

  // Next state and bump handshake; leaving GAME always returns to IDLE.
  always_comb begin
    fsm_d      = fsm_q;
    bump_ready = 1'b0;
    case (fsm_q)
      SCH_IDLE: if (in_game) fsm_d = SCH_RUN;
      SCH_RUN: begin
        bump_ready = !fifo_full;
        if (win) fsm_d = SCH_DONE;
      end
      SCH_DONE: fsm_d = SCH_DONE;
      default:  fsm_d = SCH_IDLE;
    endcase
    if (!in_game) fsm_d = SCH_IDLE;
  end

  // Accumulator: loads a new bump only once the previous one is spent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           acc <= '0;
    else if (flush)     acc <= '0;
    else if (pop)       acc <= head;
    else if (tick_fire) acc <= (acc >= STEP_ACC) ? acc - STEP_ACC : '0;
  end

  // Step output, score and win pulse; the win cycle itself takes no tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step       <= '0;
      step_valid <= 1'b0;
      score      <= '0;
      win        <= 1'b0;
    end else if (flush) begin
      step       <= '0;
      step_valid <= 1'b0;
      win        <= 1'b0;
      if ((state == GS_WAIT) || (state == GS_INFORMATION)) score <= '0;
    end else if (tick_fire) begin
      step       <= full_step ? STEP_OUT : acc[5:0];
      step_valid <= 1'b1;
      if (full_step && (score != 16'hFFFF)) begin
        score <= score + 16'd1;
        win   <= ((score + 16'd1) == WIN_SCORE);
      end else begin
        win   <= 1'b0;
      end
    end else begin
      step_valid <= 1'b0;
      win        <= 1'b0;
    end
  end

  // Sticky overflow flag for bumps refused while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   dropped <= 1'b0;
    else if (flush)                             dropped <= 1'b0;
    else if (run && bump_valid && !bump_ready)  dropped <= 1'b1;
  end

endmodule

// File: tb/tb_scroll_scheduler.sv
// Scoreboard bench for scroll_scheduler with a queue-based reference model.
module tb_scroll_scheduler;
  import game_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] WIN   = 16'd20;
  localparam logic [2:0]  G     = 3'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [2:0]  state;
  logic        hold;
  logic        bump_valid;
  logic [9:0]  bump_amt;
  logic        bump_ready;
  logic [5:0]  step;
  logic        step_valid;
  logic [15:0] score;
  logic        win;
  logic        busy;
  logic        dropped;

  typedef struct {
    int s;
    int sc;
    bit w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: phase 0 idle, 1 running, 2 finished.
  int   m_phase = 0;
  int   m_q[$];
  int   m_acc   = 0;
  int   m_score = 0;
  bit   m_win   = 0;
  bit   m_drop  = 0;

  always #5 clk = ~clk;

  scroll_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .WIN_SCORE  (WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .state      (state),
    .hold       (hold),
    .bump_valid (bump_valid),
    .bump_amt   (bump_amt),
    .bump_ready (bump_ready),
    .step       (step),
    .step_valid (step_valid),
    .score      (score),
    .win        (win),
    .busy       (busy),
    .dropped    (dropped)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_output();
    check("busy", busy, (m_acc != 0 || m_q.size() > 0) ? 1 : 0);
    check("dropped", dropped, m_drop);
    check("score", score, m_score);
  endtask

  // Apply one edge of the scrolling rules to the model.
  task automatic model_edge(input logic [2:0] st, input bit tk, input bit hd,
                            input bit bv, input int amt, input bit rdy);
    int s;
    int nacc;
    bit nwin;
    exp_t e;
    nwin = 0;
    if (st != G) begin
      m_q.delete();
      m_acc  = 0;
      m_drop = 0;
      if (st <= 3'd1) m_score = 0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      nacc = m_acc;
      if (tk && !m_win) begin
        s    = (hd || m_acc >= MAX_STEP) ? MAX_STEP : m_acc;
        nacc = (m_acc >= MAX_STEP) ? m_acc - MAX_STEP : 0;
        if (s == MAX_STEP && m_score < 65535) begin
          m_score++;
          nwin = (m_score == int'(WIN));
        end
        e.s = s; e.sc = m_score; e.w = nwin;
        sb.push_back(e);
      end
      if (m_acc == 0 && m_q.size() > 0) nacc = m_q.pop_front();
      if (bv) begin
        if (rdy) begin
          if (amt != 0) m_q.push_back(amt);
        end else begin
          m_drop = 1;
        end
      end
      if (m_win) m_phase = 2;
      m_acc = nacc;
    end
    m_win = nwin;
  endtask

  task automatic apply_stimulus(input logic [2:0] st, input bit tk, input bit hd,
                                input bit bv, input int amt);
    bit rdy;
    @(negedge clk);
    check_output();
    state      = st;
    tick       = tk;
    hold       = hd;
    bump_valid = bv;
    bump_amt   = 10'(amt);
    #1;
    rdy = (m_phase == 1) && (m_q.size() < DEPTH);
    check("bump_ready", bump_ready, rdy);
    model_edge(st, tk, hd, bv, amt, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(G, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step"}, step, 0);
    check({tag, "_step_valid"}, step_valid, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_bump_ready"}, bump_ready, 0);
  endtask

  // Asserts reset between edges, checks outputs, releases before a negedge.
  task automatic async_reset();
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_phase = 0; m_q.delete(); m_acc = 0; m_score = 0; m_win = 0; m_drop = 0;
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("ready_after_reset", bump_ready, 0);
  endtask

  // Monitor: compares every presented step against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (step_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_step_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("step", step, e.s);
          check("step_score", score, e.sc);
          check("step_win", win, e.w);
        end
      end else begin
        check("win_without_step", win, 0);
      end
    end
  end

  initial begin
    rst = 1'b0; tick = 0; hold = 0; bump_valid = 0; bump_amt = '0; state = 3'd0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Single 80-pixel bump metered out as 32, 32, 16.
    idle(1);
    apply_stimulus(G, 0, 0, 1, 80);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(G, 1, 0, 0, 0);
      idle(1);
    end

    // Hold forces a full step from a small residue.
    apply_stimulus(G, 0, 0, 1, 10);
    idle(1);
    apply_stimulus(G, 1, 1, 0, 0);
    idle(2);

    // Overfill the FIFO, then drain in order.
    for (int i = 0; i < 6; i++) apply_stimulus(G, 0, 0, 1, (i == 0) ? 40 : 10 + i);
    for (int i = 0; i < 10; i++) apply_stimulus(G, 1, 0, 0, 0);
    apply_stimulus(G, 0, 0, 1, 0);
    idle(2);

    // Leave GAME mid-drain: LOSE keeps score, WAIT clears it.
    apply_stimulus(G, 0, 0, 1, 100);
    idle(1);
    apply_stimulus(G, 1, 0, 0, 0);
    apply_stimulus(3'd4, 1, 0, 1, 50);
    idle(0);
    apply_stimulus(3'd4, 0, 0, 0, 0);
    apply_stimulus(3'd0, 0, 0, 0, 0);
    apply_stimulus(3'd0, 0, 0, 0, 0);

    // Drive to the win, then keep ticking in DONE.
    idle(1);
    for (int i = 0; i < 26; i++) apply_stimulus(G, 1, 1, 1, 33);
    idle(2);
    apply_stimulus(3'd1, 0, 0, 0, 0);

    // Asynchronous reset while running.
    idle(1);
    apply_stimulus(G, 0, 0, 1, 200);
    idle(1);
    apply_stimulus(G, 1, 0, 0, 0);
    async_reset();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      logic [2:0] st;
      int amt;
      st  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 4)) : G;
      amt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
      apply_stimulus(st, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 1) == 1, amt);
    end
    idle(3);
    @(negedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
